// File: rtl/stream_in_port.sv
// AXI4-Stream video sink: writes accepted pixels to the VDMA FIFO, checks line/frame geometry
// and emits alignment pulses. Optional statistics counters under `STREAM_IN_STAT_EN.
module stream_in_port #(
  parameter int    DSIZE      = 24,
  parameter string FRAME_SYNC = "OFF"
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [15:0]      hactive,
  input  logic [15:0]      vactive,
  input  logic [DSIZE-1:0] axi_tdata,
  input  logic             axi_tvalid,
  output logic             axi_tready,
  input  logic             axi_tuser,
  input  logic             axi_tlast,
  input  logic             axi_fsync,
  input  logic             fifo_full,
  output logic             wr_en,
  output logic [DSIZE-1:0] wr_data,
  output logic             falign,
  output logic             lalign,
  output logic             ealign,
  output logic             err_line,
`ifdef STREAM_IN_STAT_EN
  input  logic             stat_clr,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      err_cnt,
`endif
  output logic             err_frame
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam bit USE_FSYNC = (FRAME_SYNC == "ON");

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pcnt, w_pcnt_nxt;
  logic [15:0] r_lcnt, w_lcnt_nxt;
  logic [15:0] r_hact, w_hact_nxt;
  logic [15:0] r_vact, w_vact_nxt;
  logic        r_lerr, w_lerr_nxt;
  logic        r_falign, r_lalign, r_ealign, r_err_line, r_err_frame;

  logic        w_acc, w_sof, w_wr, w_line_on;
  logic        w_falign, w_lalign, w_ealign, w_err_line, w_err_frame;
  logic [15:0] w_base, w_lbase, w_hact_cur, w_vact_cur;

  // A beat transfers when tvalid and tready are both high on a rising edge; tready depends
  // only on fifo_full and rst, never on tvalid, so dropped beats drain at the same rate.
  assign axi_tready = ~fifo_full & ~rst;
  assign w_acc      = axi_tvalid & axi_tready;
  assign w_sof      = w_acc & (USE_FSYNC ? axi_fsync : axi_tuser);

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_lcnt_nxt  = r_lcnt;
    w_hact_nxt  = r_hact;
    w_vact_nxt  = r_vact;
    w_lerr_nxt  = r_lerr;
    w_wr        = 1'b0;
    w_falign    = 1'b0;
    w_lalign    = 1'b0;
    w_ealign    = 1'b0;
    w_err_line  = 1'b0;
    w_err_frame = 1'b0;
    w_hact_cur  = r_hact;
    w_vact_cur  = r_vact;
    w_base      = r_pcnt;
    w_lbase     = r_lcnt;
    w_line_on   = (r_state == ACTIVE);

    // An SOF restarts counting from the live geometry inputs in either state.
    if (w_sof) begin
      w_err_frame = (r_state == ACTIVE);
      w_hact_nxt  = hactive;
      w_vact_nxt  = vactive;
      w_hact_cur  = hactive;
      w_vact_cur  = vactive;
      w_base      = 16'd0;
      w_lbase     = 16'd0;
      w_lerr_nxt  = 1'b0;
      w_pcnt_nxt  = 16'd0;
      w_lcnt_nxt  = 16'd0;
      w_line_on   = (hactive != 16'd0) && (vactive != 16'd0);
      w_falign    = w_line_on;
      w_state_nxt = w_line_on ? ACTIVE : IDLE;
    end

    if (w_acc && w_line_on) begin
      if (w_base < w_hact_cur) begin
        w_wr       = 1'b1;
        w_pcnt_nxt = w_base + 16'd1;
      end else begin
        w_pcnt_nxt = (w_base == 16'hFFFF) ? w_base : w_base + 16'd1;
        if (!r_lerr) begin
          w_err_line = 1'b1;
          w_lerr_nxt = 1'b1;
        end
      end
      if (axi_tlast) begin
        w_lalign   = 1'b1;
        w_pcnt_nxt = 16'd0;
        w_lcnt_nxt = w_lbase + 16'd1;
        w_lerr_nxt = 1'b0;
        if (({1'b0, w_base} + 17'd1) < {1'b0, w_hact_cur}) w_err_line = 1'b1;
        if (({1'b0, w_lbase} + 17'd1) == {1'b0, w_vact_cur}) begin
          w_ealign    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pcnt      <= 16'd0;
      r_lcnt      <= 16'd0;
      r_hact      <= 16'd0;
      r_vact      <= 16'd0;
      r_lerr      <= 1'b0;
      r_falign    <= 1'b0;
      r_lalign    <= 1'b0;
      r_ealign    <= 1'b0;
      r_err_line  <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pcnt      <= w_pcnt_nxt;
      r_lcnt      <= w_lcnt_nxt;
      r_hact      <= w_hact_nxt;
      r_vact      <= w_vact_nxt;
      r_lerr      <= w_lerr_nxt;
      r_falign    <= w_falign;
      r_lalign    <= w_lalign;
      r_ealign    <= w_ealign;
      r_err_line  <= w_err_line;
      r_err_frame <= w_err_frame;
    end
  end

  assign wr_en     = w_wr;
  assign wr_data   = axi_tdata;
  assign falign    = r_falign;
  assign lalign    = r_lalign;
  assign ealign    = r_ealign;
  assign err_line  = r_err_line;
  assign err_frame = r_err_frame;

`ifdef STREAM_IN_STAT_EN
  logic [15:0] r_drop_cnt, r_err_cnt;
  logic [16:0] w_err_sum;

  // Error pulses are counted from their registered form, so both can land in one cycle.
  assign w_err_sum = {1'b0, r_err_cnt} + {16'd0, r_err_line} + {16'd0, r_err_frame};

  always_ff @(posedge clock) begin
    if (rst || stat_clr) begin
      r_drop_cnt <= 16'd0;
      r_err_cnt  <= 16'd0;
    end else begin
      if (w_acc && !w_wr && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign err_cnt  = r_err_cnt;
`endif

endmodule

// File: tb/tb_stream_in_port.sv
// Directed bench for stream_in_port: per-beat write/pulse checks plus a written-pixel scoreboard.
module tb_stream_in_port;

  localparam int DSIZE = 24;
  // Pulse vector layout: {falign, lalign, ealign, err_line, err_frame}
  localparam logic [4:0] P0 = 5'b00000;
  localparam logic [4:0] PF = 5'b10000;
  localparam logic [4:0] PL = 5'b01000;
  localparam logic [4:0] PE = 5'b00100;
  localparam logic [4:0] PEL = 5'b00010;
  localparam logic [4:0] PEF = 5'b00001;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      hactive = 16'd4;
  logic [15:0]      vactive = 16'd2;
  logic [DSIZE-1:0] axi_tdata = '0;
  logic             axi_tvalid = 1'b0;
  logic             axi_tready;
  logic             axi_tuser = 1'b0;
  logic             axi_tlast = 1'b0;
  logic             axi_fsync = 1'b0;
  logic             fifo_full = 1'b0;
  logic             wr_en;
  logic [DSIZE-1:0] wr_data;
  logic             falign, lalign, ealign, err_line, err_frame;
`ifdef STREAM_IN_STAT_EN
  logic             stat_clr = 1'b0;
  logic [15:0]      drop_cnt, err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [DSIZE-1:0] exp_q[$];
  logic [DSIZE-1:0] got_q[$];

  stream_in_port #(.DSIZE(DSIZE), .FRAME_SYNC("OFF")) dut (
    .clock(clock), .rst(rst), .hactive(hactive), .vactive(vactive),
    .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid), .axi_tready(axi_tready),
    .axi_tuser(axi_tuser), .axi_tlast(axi_tlast), .axi_fsync(axi_fsync),
    .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
    .falign(falign), .lalign(lalign), .ealign(ealign), .err_line(err_line),
`ifdef STREAM_IN_STAT_EN
    .stat_clr(stat_clr), .drop_cnt(drop_cnt), .err_cnt(err_cnt),
`endif
    .err_frame(err_frame)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard capture: one entry per FIFO write
  always @(negedge clock) if (wr_en) got_q.push_back(wr_data);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one beat (optionally stalled by fifo_full), check the zero-latency write and,
  // one cycle after acceptance, the registered pulses.
  task automatic beat(input logic [DSIZE-1:0] d, input logic u, input logic l,
                      input logic xw, input logic [4:0] xp, input int stall);
    @(posedge clock); #1;
    axi_tdata = d; axi_tuser = u; axi_tlast = l; axi_tvalid = 1'b1;
    fifo_full = (stall != 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      check("stall_tready", {31'd0, axi_tready}, 32'd0);
      check("stall_wr_en", {31'd0, wr_en}, 32'd0);
      @(posedge clock); #1;
    end
    fifo_full = 1'b0;
    @(negedge clock);
    check("tready", {31'd0, axi_tready}, 32'd1);
    check("wr_en", {31'd0, wr_en}, {31'd0, xw});
    if (xw) begin
      check("wr_data", {8'd0, wr_data}, {8'd0, d});
      exp_q.push_back(d);
    end
    @(posedge clock); #1;
    axi_tvalid = 1'b0; axi_tuser = 1'b0; axi_tlast = 1'b0;
    @(negedge clock);
    check("pulses", {27'd0, falign, lalign, ealign, err_line, err_frame}, {27'd0, xp});
  endtask

  initial begin
    // reset: tvalid high but nothing may be accepted
    axi_tvalid = 1'b1; axi_tuser = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("rst_tready", {31'd0, axi_tready}, 32'd0);
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_pulses", {27'd0, falign, lalign, ealign, err_line, err_frame}, 32'd0);
    end
    @(posedge clock); #1;
    rst = 1'b0; axi_tvalid = 1'b0; axi_tuser = 1'b0;

    // clean 4x2 frame; hactive change mid-frame must be ignored
    hactive = 16'd4; vactive = 16'd2;
    beat(24'hA00001, 1, 0, 1, PF, 0);
    hactive = 16'd7;
    beat(24'hA00002, 0, 0, 1, P0, 0);
    beat(24'hA00003, 0, 0, 1, P0, 0);
    beat(24'hA00004, 0, 1, 1, PL, 0);
    beat(24'hA00005, 0, 0, 1, P0, 0);
    beat(24'hA00006, 0, 0, 1, P0, 0);
    beat(24'hA00007, 0, 0, 1, P0, 0);
    beat(24'hA00008, 0, 1, 1, PL | PE, 0);

    // beats without SOF are dropped in IDLE, then a 4x1 frame
    hactive = 16'd4; vactive = 16'd1;
    beat(24'hB00001, 0, 0, 0, P0, 0);
    beat(24'hB00002, 0, 1, 0, P0, 0);
    beat(24'hB00003, 0, 0, 0, P0, 0);
    beat(24'hB00004, 1, 0, 1, PF, 0);
    beat(24'hB00005, 0, 0, 1, P0, 0);
    beat(24'hB00006, 0, 0, 1, P0, 0);
    beat(24'hB00007, 0, 1, 1, PL | PE, 0);

    // short line, then a normal line
    vactive = 16'd2;
    beat(24'hC00001, 1, 0, 1, PF, 0);
    beat(24'hC00002, 0, 1, 1, PL | PEL, 0);
    beat(24'hC00003, 0, 0, 1, P0, 0);
    beat(24'hC00004, 0, 0, 1, P0, 0);
    beat(24'hC00005, 0, 0, 1, P0, 0);
    beat(24'hC00006, 0, 1, 1, PL | PE, 0);

    // long line: 6 beats, only the first dropped beat flags err_line
    vactive = 16'd1;
    beat(24'hD00001, 1, 0, 1, PF, 0);
    beat(24'hD00002, 0, 0, 1, P0, 0);
    beat(24'hD00003, 0, 0, 1, P0, 0);
    beat(24'hD00004, 0, 0, 1, P0, 0);
    beat(24'hD00005, 0, 0, 0, PEL, 0);
    beat(24'hD00006, 0, 1, 0, PL | PE, 0);

    // SOF mid-line restarts the frame, which then completes
    vactive = 16'd2;
    beat(24'hE00001, 1, 0, 1, PF, 0);
    beat(24'hE00002, 0, 0, 1, P0, 0);
    beat(24'hE00003, 1, 0, 1, PF | PEF, 0);
    beat(24'hE00004, 0, 0, 1, P0, 0);
    beat(24'hE00005, 0, 0, 1, P0, 0);
    beat(24'hE00006, 0, 1, 1, PL, 0);
    beat(24'hE00007, 0, 0, 1, P0, 0);
    beat(24'hE00008, 0, 0, 1, P0, 0);
    beat(24'hE00009, 0, 0, 1, P0, 0);
    beat(24'hE0000A, 0, 1, 1, PL | PE, 0);

    // fifo_full stall mid-line
    vactive = 16'd1;
    beat(24'hF00001, 1, 0, 1, PF, 0);
    beat(24'hF00002, 0, 0, 1, P0, 5);
    beat(24'hF00003, 0, 0, 1, P0, 0);
    beat(24'hF00004, 0, 1, 1, PL | PE, 0);

    // single-pixel lines
    hactive = 16'd1; vactive = 16'd2;
    beat(24'h110001, 1, 1, 1, PF | PL, 0);
    beat(24'h110002, 0, 1, 1, PL | PE, 0);

    // zero geometry: SOF ignored, block stays idle
    hactive = 16'd0; vactive = 16'd2;
    beat(24'h220001, 1, 0, 0, P0, 0);
    hactive = 16'd4;
    beat(24'h220002, 0, 0, 0, P0, 0);

    // scoreboard: every written pixel, in order, no loss or duplication
    repeat (2) @(posedge clock);
    check("sb_count", got_q.size(), exp_q.size());
    while (exp_q.size() != 0 && got_q.size() != 0)
      check("sb_data", {8'd0, got_q.pop_front()}, {8'd0, exp_q.pop_front()});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
